// File: rtl/rf_port_master_if.sv
`default_nettype none
// ============================================================================
// Module  : rf_port_master_if
// Brief   : Bundle of request, response, writeback and RF port signals for
//           rf_port_master (master side) and its environment (slave side).
// Revision: 1.0 - initial release
// ============================================================================
interface rf_port_master_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_SIZE  = 5
);
  logic                  init_done;
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_use;
  logic [ADDR_SIZE-1:0]  req_rs1, req_rs2, req_rs3;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WORD_WIDTH-1:0] rsp_op1, rsp_op2, rsp_op3;
  logic                  wb1_valid, wb2_valid;
  logic [ADDR_SIZE-1:0]  wb1_addr, wb2_addr;
  logic [WORD_WIDTH-1:0] wb1_data, wb2_data;
  logic                  wb_ready;
  logic                  rf_re1, rf_re2, rf_re3;
  logic [ADDR_SIZE-1:0]  rf_ra1, rf_ra2, rf_ra3;
  logic [WORD_WIDTH-1:0] rf_rd1, rf_rd2, rf_rd3;
  logic                  rf_we1, rf_we2;
  logic [ADDR_SIZE-1:0]  rf_wa1, rf_wa2;
  logic [WORD_WIDTH-1:0] rf_wd1, rf_wd2;

  modport master (
    output init_done, req_ready, rsp_valid, rsp_op1, rsp_op2, rsp_op3, wb_ready,
           rf_re1, rf_re2, rf_re3, rf_ra1, rf_ra2, rf_ra3,
           rf_we1, rf_we2, rf_wa1, rf_wa2, rf_wd1, rf_wd2,
    input  req_valid, req_use, req_rs1, req_rs2, req_rs3, rsp_ready,
           wb1_valid, wb2_valid, wb1_addr, wb2_addr, wb1_data, wb2_data,
           rf_rd1, rf_rd2, rf_rd3
  );

  modport slave (
    input  init_done, req_ready, rsp_valid, rsp_op1, rsp_op2, rsp_op3, wb_ready,
           rf_re1, rf_re2, rf_re3, rf_ra1, rf_ra2, rf_ra3,
           rf_we1, rf_we2, rf_wa1, rf_wa2, rf_wd1, rf_wd2,
    output req_valid, req_use, req_rs1, req_rs2, req_rs3, rsp_ready,
           wb1_valid, wb2_valid, wb1_addr, wb2_addr, wb1_data, wb2_data,
           rf_rd1, rf_rd2, rf_rd3
  );
endinterface
`default_nettype wire

// File: rtl/rf_port_master.sv
`default_nettype none
// ============================================================================
// Module  : rf_port_master
// Brief   : Initiator for a 3R/2W register file: INIT fill, operand fetch with
//           writeback bypass, dual writeback sequencing. Option: ZERO_REG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rf_port_master #(
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    RF_SIZE     = 32,
  parameter int                    ADDR_SIZE   = 5,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  rf_port_master_if.master bus
);
  localparam logic [0:0] c_S_INIT = 1'b0;
  localparam logic [0:0] c_S_RUN  = 1'b1;
  localparam logic [ADDR_SIZE-1:0] c_INIT_LAST = ADDR_SIZE'(RF_SIZE / 2 - 1);
`ifdef ZERO_REG_EN
  localparam bit c_ZERO_REG = 1'b1;
`else
  localparam bit c_ZERO_REG = 1'b0;
`endif

  logic [0:0]            r_state;
  logic [ADDR_SIZE-1:0]  r_init_cnt;
  logic                  r_rsp_valid;
  logic [WORD_WIDTH-1:0] r_op1, r_op2, r_op3;

  logic                  w_run, w_init, w_req_ready, w_accept;
  logic                  w_we1_run, w_we2_run;
  logic [ADDR_SIZE-1:0]  w_wb1_addr, w_wb2_addr;
  logic [WORD_WIDTH-1:0] w_wb1_data, w_wb2_data;
  logic [WORD_WIDTH-1:0] w_op1, w_op2, w_op3;

  assign w_run       = (r_state == c_S_RUN);
  assign w_init      = (r_state == c_S_INIT);
  assign w_req_ready = w_run && (!r_rsp_valid || bus.rsp_ready);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_wb1_addr  = bus.wb1_addr;
  assign w_wb2_addr  = bus.wb2_addr;
  assign w_wb1_data  = bus.wb1_data;
  assign w_wb2_data  = bus.wb2_data;

  // wb2 owns a shared address; hard-zero register swallows writes
  assign w_we2_run = w_run && bus.wb2_valid && !(c_ZERO_REG && w_wb2_addr == '0);
  assign w_we1_run = w_run && bus.wb1_valid && !(c_ZERO_REG && w_wb1_addr == '0)
                     && !(bus.wb2_valid && w_wb1_addr == w_wb2_addr);

  // The RF write lands on the capture edge, so matching writebacks bypass rf_rd
  function automatic logic [WORD_WIDTH-1:0] f_operand(
    input logic                  use_en,
    input logic [ADDR_SIZE-1:0]  addr,
    input logic [WORD_WIDTH-1:0] rd
  );
    logic [WORD_WIDTH-1:0] v;
    if (!use_en || (c_ZERO_REG && addr == '0)) v = '0;
    else if (w_we2_run && w_wb2_addr == addr)  v = w_wb2_data;
    else if (w_we1_run && w_wb1_addr == addr)  v = w_wb1_data;
    else                                       v = rd;
    return v;
  endfunction

  assign w_op1 = f_operand(bus.req_use[0], bus.req_rs1, bus.rf_rd1);
  assign w_op2 = f_operand(bus.req_use[1], bus.req_rs2, bus.rf_rd2);
  assign w_op3 = f_operand(bus.req_use[2], bus.req_rs3, bus.rf_rd3);

  assign bus.init_done = w_run;
  assign bus.wb_ready  = w_run;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_op1   = r_op1;
  assign bus.rsp_op2   = r_op2;
  assign bus.rsp_op3   = r_op3;

  assign bus.rf_re1 = w_accept && bus.req_use[0];
  assign bus.rf_re2 = w_accept && bus.req_use[1];
  assign bus.rf_re3 = w_accept && bus.req_use[2];
  assign bus.rf_ra1 = bus.req_rs1;
  assign bus.rf_ra2 = bus.req_rs2;
  assign bus.rf_ra3 = bus.req_rs3;

  // INIT writes register pair 2k/2k+1 per cycle; held off while rst is high
  assign bus.rf_we1 = w_init ? !rst : w_we1_run;
  assign bus.rf_we2 = w_init ? !rst : w_we2_run;
  assign bus.rf_wa1 = w_init ? {r_init_cnt[ADDR_SIZE-2:0], 1'b0} : w_wb1_addr;
  assign bus.rf_wa2 = w_init ? {r_init_cnt[ADDR_SIZE-2:0], 1'b1} : w_wb2_addr;
  assign bus.rf_wd1 = w_init ? RESET_VALUE : w_wb1_data;
  assign bus.rf_wd2 = w_init ? RESET_VALUE : w_wb2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_S_INIT;
      r_init_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_op3       <= '0;
    end else begin
      if (w_init) begin
        if (r_init_cnt == c_INIT_LAST) r_state <= c_S_RUN;
        else                           r_init_cnt <= r_init_cnt + ADDR_SIZE'(1);
      end
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_op3       <= w_op3;
      end else if (bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rf_port_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_port_master
// Brief   : Scoreboard bench with an architectural register model and an RF
//           memory model. Honours ZERO_REG_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rf_port_master;
  localparam int NREG = 32;
  localparam logic [31:0] RV = 32'h0;
`ifdef ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  typedef struct packed { logic [31:0] o1, o2, o3; } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_port_master_if #(.WORD_WIDTH(32), .ADDR_SIZE(5)) bus ();

  rf_port_master #(.WORD_WIDTH(32), .RF_SIZE(NREG), .ADDR_SIZE(5), .RESET_VALUE(RV))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file memory: asynchronous read, 0 on a disabled port
  logic [31:0] rf_mem [0:NREG-1];
  always @(posedge clk) begin
    if (bus.rf_we1 === 1'b1) rf_mem[bus.rf_wa1] <= bus.rf_wd1;
    if (bus.rf_we2 === 1'b1) rf_mem[bus.rf_wa2] <= bus.rf_wd2;
  end
  assign bus.rf_rd1 = bus.rf_re1 ? rf_mem[bus.rf_ra1] : 32'h0;
  assign bus.rf_rd2 = bus.rf_re2 ? rf_mem[bus.rf_ra2] : 32'h0;
  assign bus.rf_rd3 = bus.rf_re3 ? rf_mem[bus.rf_ra3] : 32'h0;

  // Architectural model: register contents as seen by the program
  logic [31:0] arch [0:NREG-1];
  bit known = 0, pending = 0;
  int init_left = 0;

  function automatic logic [31:0] mval(input logic u, input logic [4:0] a);
    if (!u || (ZERO && a == 5'd0)) return 32'h0;
    return arch[a];
  endfunction

  always @(negedge clk) begin
    #1;
    if (rst === 1'b1) begin
      known = 1; init_left = NREG / 2; pending = 0;
      exp_q.delete();
      for (int i = 0; i < NREG; i++) arch[i] = RV;
    end else if (known && init_left > 0) begin
      automatic int k = NREG / 2 - init_left;
      chk("init_we1", bus.rf_we1, 1);
      chk("init_we2", bus.rf_we2, 1);
      chk("init_wa1", bus.rf_wa1, 2 * k);
      chk("init_wa2", bus.rf_wa2, 2 * k + 1);
      chk("init_wd1", bus.rf_wd1, RV);
      chk("init_wd2", bus.rf_wd2, RV);
      chk("init_done_low", bus.init_done, 0);
      chk("init_req_ready", bus.req_ready, 0);
      chk("init_wb_ready", bus.wb_ready, 0);
      chk("init_re", {bus.rf_re1, bus.rf_re2, bus.rf_re3}, 0);
      if (k == 0) begin
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_ops", bus.rsp_op1 | bus.rsp_op2 | bus.rsp_op3, 0);
      end
      init_left--;
    end else if (known) begin
      automatic logic rdy = !pending || bus.rsp_ready;
      automatic logic acc = bus.req_valid && rdy;
      automatic logic z1 = ZERO && bus.wb1_addr == 5'd0;
      automatic logic z2 = ZERO && bus.wb2_addr == 5'd0;
      automatic logic e_we1 = bus.wb1_valid && !z1 && !(bus.wb2_valid && bus.wb1_addr == bus.wb2_addr);
      automatic logic e_we2 = bus.wb2_valid && !z2;
      chk("init_done", bus.init_done, 1);
      chk("wb_ready", bus.wb_ready, 1);
      chk("req_ready", bus.req_ready, rdy);
      chk("rf_we1", bus.rf_we1, e_we1);
      chk("rf_we2", bus.rf_we2, e_we2);
      if (e_we1) begin chk("rf_wa1", bus.rf_wa1, bus.wb1_addr); chk("rf_wd1", bus.rf_wd1, bus.wb1_data); end
      if (e_we2) begin chk("rf_wa2", bus.rf_wa2, bus.wb2_addr); chk("rf_wd2", bus.rf_wd2, bus.wb2_data); end
      chk("rf_re", {bus.rf_re1, bus.rf_re2, bus.rf_re3},
          acc ? {bus.req_use[0], bus.req_use[1], bus.req_use[2]} : 3'b000);
      if (acc && bus.req_use[0]) chk("rf_ra1", bus.rf_ra1, bus.req_rs1);
      // Apply writebacks in order: wb2 lands last and therefore wins
      if (bus.wb1_valid && !z1) arch[bus.wb1_addr] = bus.wb1_data;
      if (bus.wb2_valid && !z2) arch[bus.wb2_addr] = bus.wb2_data;
      if (acc)
        exp_q.push_back('{mval(bus.req_use[0], bus.req_rs1),
                          mval(bus.req_use[1], bus.req_rs2),
                          mval(bus.req_use[2], bus.req_rs3)});
      pending = acc ? 1'b1 : (bus.rsp_ready ? 1'b0 : pending);
    end
  end

  // Response monitor: held responses are compared every cycle until drained
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
      else begin
        chk("rsp_op1", bus.rsp_op1, exp_q[0].o1);
        chk("rsp_op2", bus.rsp_op2, exp_q[0].o2);
        chk("rsp_op3", bus.rsp_op3, exp_q[0].o3);
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end else if (known && exp_q.size() > 0) begin
      chk("rsp_missing", bus.rsp_valid, 1);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.req_valid = 0; bus.req_use = 3'b000;
    bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_rs3 = 0;
    bus.wb1_valid = 0; bus.wb1_addr = 0; bus.wb1_data = 0;
    bus.wb2_valid = 0; bus.wb2_addr = 0; bus.wb2_data = 0;
    bus.rsp_ready = 1;
  endtask

  task automatic req(input logic [2:0] u, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
    bus.req_valid = 1; bus.req_use = u;
    bus.req_rs1 = a1; bus.req_rs2 = a2; bus.req_rs3 = a3;
  endtask

  task automatic wb1(input logic [4:0] a, input logic [31:0] d);
    bus.wb1_valid = 1; bus.wb1_addr = a; bus.wb1_data = d;
  endtask

  task automatic wb2(input logic [4:0] a, input logic [31:0] d);
    bus.wb2_valid = 1; bus.wb2_addr = a; bus.wb2_data = d;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1; idle();
    repeat (3) step();
    rst = 0;
    repeat (NREG / 2 + 2) step();

    // Every register reads back the fill value
    for (int i = 0; i < 11; i++) begin
      req(3'b111, 5'((3 * i) % NREG), 5'((3 * i + 1) % NREG), 5'((3 * i + 2) % NREG));
      step();
    end
    idle(); step();

    wb1(5, 32'hA5A5A5A5); step();
    idle(); req(3'b001, 5, 0, 0); step();
    idle(); step();

    req(3'b001, 7, 0, 0); wb2(7, 32'h00001234); step();
    idle(); req(3'b001, 7, 0, 0); step();
    idle(); step();

    wb1(9, 32'h1111); wb2(9, 32'h2222); step();
    idle(); req(3'b001, 9, 0, 0); step();
    idle(); step();

    // Stalled response must not pick up a later writeback
    wb1(3, 32'h10); step();
    idle(); req(3'b001, 3, 0, 0); step();
    idle(); bus.rsp_ready = 0; req(3'b001, 4, 0, 0); wb1(3, 32'h99);
    repeat (3) step();
    idle(); repeat (2) step();

    for (int n = 0; n < 400; n++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_use   = 3'($urandom_range(0, 7));
      bus.req_rs1 = raddr(); bus.req_rs2 = raddr(); bus.req_rs3 = raddr();
      bus.wb1_valid = 1'($urandom_range(0, 1));
      bus.wb1_addr  = raddr(); bus.wb1_data = $urandom;
      bus.wb2_valid = 1'($urandom_range(0, 1));
      bus.wb2_addr  = raddr(); bus.wb2_data = $urandom;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(); repeat (2) step();

    // Reset while a response is outstanding
    req(3'b001, 1, 0, 0); step();
    idle(); bus.rsp_ready = 0; rst = 1; step();
    rst = 0; bus.rsp_ready = 1;
    repeat (NREG / 2 + 2) step();

    wb1(0, 32'hFF); step();
    idle(); req(3'b001, 0, 0, 0); step();
    idle(); repeat (3) step();

    chk("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
